// File: rtl/subservient_wb_arbiter_pkg.sv
// Shared types and helpers for the subservient two-master Wishbone arbiter.
package subservient_wb_arbiter_pkg;

    // Arbiter states: wait for a request, run one transaction, swallow one cycle after a timeout
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Master indices, also used as the value of the "last served" register
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // One master's request side bundled so the slave mux selects a single vector
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        stb;
    } wb_req_t;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last
    function automatic logic rr_pick(input logic stb0, input logic stb1, input logic last);
        logic pick;
        if (stb0 && stb1) begin
            pick = ~last;
        end else if (stb1) begin
            pick = M1;
        end else begin
            pick = M0;
        end
        return pick;
    endfunction

    // Convert a master index into the one-hot grant vector seen on o_grant
    function automatic logic [1:0] idx_to_grant(input logic idx);
        return (idx == M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/subservient_wb_wdog.sv
// Transaction watchdog: counts busy cycles without ack, saturates, flags terminal count.
module subservient_wb_wdog
    import subservient_wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    assign o_tc = &cnt_q;

    // Next count: clear has priority, otherwise step while enabled and hold at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && !o_tc) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    // Counter register, cleared immediately by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/subservient_wb_arbiter.sv
// Two-master to one-slave Wishbone arbiter: round-robin per transaction, grant held
// until slave ack, watchdog terminates hung transactions with an error read word.
module subservient_wb_arbiter
    import subservient_wb_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_W = 8,
    parameter logic [31:0] ERR_RDT   = 32'hDEAD_BEEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // master 0: core external data port
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    input  logic [3:0]  i_m0_sel,
    input  logic        i_m0_we,
    input  logic        i_m0_stb,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    // master 1: debug / host port
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_stb,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    // slave: peripheral bus
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    output logic [3:0]  o_s_sel,
    output logic        o_s_we,
    output logic        o_s_stb,
    input  logic [31:0] i_s_rdt,
    input  logic        i_s_ack,
    // status
    output logic        o_timeout,
    output logic [1:0]  o_grant
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic [1:0]  grant_q;
    logic [1:0]  grant_d;
    logic        last_q;
    logic        last_d;

    wb_req_t     m0Req;
    wb_req_t     m1Req;
    wb_req_t     ownReq;
    logic        ownIdx;
    logic        ackOwn;
    logic [31:0] rdtOwn;
    logic        wdogClr;
    logic        wdogEn;
    logic        wdogTc;

    assign m0Req   = '{adr: i_m0_adr, dat: i_m0_dat, sel: i_m0_sel, we: i_m0_we, stb: i_m0_stb};
    assign m1Req   = '{adr: i_m1_adr, dat: i_m1_dat, sel: i_m1_sel, we: i_m1_we, stb: i_m1_stb};

    // The grant is one-hot while busy, so its upper bit is the owner's index
    assign ownIdx  = grant_q[1];
    assign ownReq  = (ownIdx == M1) ? m1Req : m0Req;
    assign o_grant = grant_q;

    // Watchdog runs only across consecutive busy cycles and restarts whenever we leave BUSY
    assign wdogClr = (state_d != BUSY);
    assign wdogEn  = (state_q == BUSY) && !i_s_ack;

    subservient_wb_wdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdog (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (wdogClr),
        .i_en    (wdogEn),
        .o_tc    (wdogTc)
    );

    // Next-state, slave drive and owner response; ack beats abort beats timeout
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        ackOwn    = 1'b0;
        rdtOwn    = '0;
        o_timeout = 1'b0;
        o_s_adr   = '0;
        o_s_dat   = '0;
        o_s_sel   = '0;
        o_s_we    = 1'b0;
        o_s_stb   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_m0_stb || i_m1_stb) begin
                    grant_d = idx_to_grant(rr_pick(i_m0_stb, i_m1_stb, last_q));
                    state_d = BUSY;
                end
            end

            BUSY: begin
                o_s_adr = ownReq.adr;
                o_s_dat = ownReq.dat;
                o_s_sel = ownReq.sel;
                o_s_we  = ownReq.we;
                o_s_stb = ownReq.stb;
                if (i_s_ack) begin
                    ackOwn  = 1'b1;
                    rdtOwn  = i_s_rdt;
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = ownIdx;
                end else if (!ownReq.stb) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else if (wdogTc) begin
                    ackOwn    = 1'b1;
                    rdtOwn    = ERR_RDT;
                    o_timeout = 1'b1;
                    o_s_stb   = 1'b0;
                    state_d   = DRAIN;
                    grant_d   = 2'b00;
                    last_d    = ownIdx;
                end
            end

            DRAIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Route the owner's ack and read data; the other master always sees zeros
    always_comb begin
        o_m0_ack = ackOwn && (ownIdx == M0);
        o_m1_ack = ackOwn && (ownIdx == M1);
        o_m0_rdt = o_m0_ack ? rdtOwn : '0;
        o_m1_rdt = o_m1_ack ? rdtOwn : '0;
    end

    // State, grant and round-robin history registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= M1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_subservient_wb_arbiter.sv
// Self-checking bench for subservient_wb_arbiter: transaction-level model compared every cycle,
// plus hand-computed literal expectations on key cycles.
module tb_subservient_wb_arbiter;

    localparam int          TW    = 4;
    localparam int          LIMIT = (1 << TW) - 1;
    localparam logic [31:0] ERR   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0Adr, m0Dat, m1Adr, m1Dat;
    logic [3:0]  m0Sel, m1Sel;
    logic        m0We, m0Stb, m1We, m1Stb;
    logic [31:0] sRdt;
    logic        sAck;

    logic [31:0] m0Rdt, m1Rdt, sAdr, sDat;
    logic        m0Ack, m1Ack, sWe, sStb, timeoutOut;
    logic [3:0]  sSel;
    logic [1:0]  grant;

    int checks = 0;
    int passes = 0;

    // Transaction-level model: who owns the bus, who was served last, how long we have waited
    bit mBusy   = 1'b0;
    bit mDrain  = 1'b0;
    int mOwner  = 0;
    int mLast   = 1;
    int mWaited = 0;

    subservient_wb_arbiter #(
        .TIMEOUT_W (TW),
        .ERR_RDT   (ERR)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_m0_adr  (m0Adr),
        .i_m0_dat  (m0Dat),
        .i_m0_sel  (m0Sel),
        .i_m0_we   (m0We),
        .i_m0_stb  (m0Stb),
        .o_m0_rdt  (m0Rdt),
        .o_m0_ack  (m0Ack),
        .i_m1_adr  (m1Adr),
        .i_m1_dat  (m1Dat),
        .i_m1_sel  (m1Sel),
        .i_m1_we   (m1We),
        .i_m1_stb  (m1Stb),
        .o_m1_rdt  (m1Rdt),
        .o_m1_ack  (m1Ack),
        .o_s_adr   (sAdr),
        .o_s_dat   (sDat),
        .o_s_sel   (sSel),
        .o_s_we    (sWe),
        .o_s_stb   (sStb),
        .i_s_rdt   (sRdt),
        .i_s_ack   (sAck),
        .o_timeout (timeoutOut),
        .o_grant   (grant)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's request/response inputs, then settle 2 time units into the cycle
    task automatic applyStimulus(input logic s0, input logic s1, input logic ack, input logic [31:0] rdt);
        m0Stb = s0;
        m1Stb = s1;
        sAck  = ack;
        sRdt  = rdt;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycle(input logic s0, input logic s1, input logic ack, input logic [31:0] rdt);
        applyStimulus(s0, s1, ack, rdt);
        nextCycle();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
    endtask

    // Every cycle: derive the required outputs from the model, compare, then advance the model
    always @(negedge clk) begin : compareProc
        logic [31:0] eAdr, eDat, eR0, eR1;
        logic [3:0]  eSel;
        logic        eWe, eStb, eA0, eA1, eTo, ownStb;
        logic [1:0]  eGnt;
        eAdr = '0; eDat = '0; eR0 = '0; eR1 = '0; eSel = '0;
        eWe = 1'b0; eStb = 1'b0; eA0 = 1'b0; eA1 = 1'b0; eTo = 1'b0; ownStb = 1'b0;
        eGnt = 2'b00;
        if (!rst_n) begin
            mBusy = 1'b0; mDrain = 1'b0; mLast = 1; mWaited = 0; mOwner = 0;
        end else if (mBusy) begin
            ownStb = (mOwner == 1) ? m1Stb : m0Stb;
            eAdr   = (mOwner == 1) ? m1Adr : m0Adr;
            eDat   = (mOwner == 1) ? m1Dat : m0Dat;
            eSel   = (mOwner == 1) ? m1Sel : m0Sel;
            eWe    = (mOwner == 1) ? m1We  : m0We;
            eGnt   = (mOwner == 1) ? 2'b10 : 2'b01;
            eStb   = ownStb;
            if (sAck) begin
                if (mOwner == 1) begin eA1 = 1'b1; eR1 = sRdt; end
                else             begin eA0 = 1'b1; eR0 = sRdt; end
                mBusy = 1'b0;
                mLast = mOwner;
            end else if (!ownStb) begin
                mBusy = 1'b0;
            end else if (mWaited == LIMIT) begin
                if (mOwner == 1) begin eA1 = 1'b1; eR1 = ERR; end
                else             begin eA0 = 1'b1; eR0 = ERR; end
                eTo    = 1'b1;
                eStb   = 1'b0;
                mBusy  = 1'b0;
                mDrain = 1'b1;
                mLast  = mOwner;
            end else begin
                mWaited++;
            end
        end else if (mDrain) begin
            mDrain = 1'b0;
        end else if (m0Stb || m1Stb) begin
            if (m0Stb && m1Stb) mOwner = 1 - mLast;
            else                mOwner = m1Stb ? 1 : 0;
            mBusy   = 1'b1;
            mWaited = 0;
        end
        checkOutput("s_adr",   sAdr, eAdr);
        checkOutput("s_dat",   sDat, eDat);
        checkOutput("s_sel",   {28'b0, sSel}, {28'b0, eSel});
        checkOutput("s_we",    {31'b0, sWe}, {31'b0, eWe});
        checkOutput("s_stb",   {31'b0, sStb}, {31'b0, eStb});
        checkOutput("m0_ack",  {31'b0, m0Ack}, {31'b0, eA0});
        checkOutput("m0_rdt",  m0Rdt, eR0);
        checkOutput("m1_ack",  {31'b0, m1Ack}, {31'b0, eA1});
        checkOutput("m1_rdt",  m1Rdt, eR1);
        checkOutput("timeout", {31'b0, timeoutOut}, {31'b0, eTo});
        checkOutput("grant",   {30'b0, grant}, {30'b0, eGnt});
    end

    initial begin
        rst_n = 1'b0;
        m0Adr = 32'h4000_0010; m0Dat = 32'h1234_5678; m0Sel = 4'hF; m0We = 1'b1; m0Stb = 1'b0;
        m1Adr = 32'h8000_0020; m1Dat = 32'hAAAA_5555; m1Sel = 4'h3; m1We = 1'b0; m1Stb = 1'b0;
        sAck  = 1'b0; sRdt = '0;
        #1;
        checkOutput("rstGrantLit", {30'b0, grant}, 32'd0);
        checkOutput("rstStbLit",   {31'b0, sStb},  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single m0 write, slave acks two cycles after o_s_stb rises
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1IdleStbLit", {31'b0, sStb}, 32'd0);
        nextCycle();
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1StbLit",   {31'b0, sStb}, 32'd1);
        checkOutput("t1AdrLit",   sAdr, 32'h4000_0010);
        checkOutput("t1DatLit",   sDat, 32'h1234_5678);
        checkOutput("t1GrantLit", {30'b0, grant}, 32'd1);
        nextCycle();
        runCycle(1, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h0);
        checkOutput("t1AckLit",   {31'b0, m0Ack}, 32'd1);
        checkOutput("t1M1AckLit", {31'b0, m1Ack}, 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1GrantIdleLit", {30'b0, grant}, 32'd0);
        nextCycle();

        // Simultaneous requests from reset: m0 first, m1 next
        doReset();
        runCycle(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("t2FirstGrantLit", {30'b0, grant}, 32'd1);
        nextCycle();
        runCycle(1, 1, 1, 32'h0101_0101);
        runCycle(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t2SecondGrantLit", {30'b0, grant}, 32'd2);
        checkOutput("t2SelLit", {28'b0, sSel}, 32'd3);
        nextCycle();
        runCycle(0, 1, 1, 32'h0202_0202);
        runCycle(0, 0, 0, 0);

        // Back-to-back ties alternate owners (last served was m1)
        for (int t = 0; t < 6; t++) begin
            runCycle(1, 1, 0, 0);
            runCycle(1, 1, 0, 0);
            applyStimulus(1, 1, 1, 32'h0000_1000 + 32'(t));
            checkOutput("rrAck0Lit", {31'b0, m0Ack}, (t % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rrAck1Lit", {31'b0, m1Ack}, (t % 2 == 0) ? 32'd0 : 32'd1);
            nextCycle();
            runCycle(0, 0, 0, 0);
        end

        // Read data routing to m1
        runCycle(0, 1, 0, 0);
        runCycle(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 32'hCAFE_F00D);
        checkOutput("t3M1RdtLit", m1Rdt, 32'hCAFE_F00D);
        checkOutput("t3M0RdtLit", m0Rdt, 32'd0);
        nextCycle();
        runCycle(0, 0, 0, 0);

        // Watchdog: slave never acks, late ack in DRAIN is swallowed, m1 then completes
        runCycle(1, 0, 0, 0);
        for (int i = 0; i < LIMIT; i++) runCycle(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t4AckLit", {31'b0, m0Ack}, 32'd1);
        checkOutput("t4RdtLit", m0Rdt, 32'hDEAD_BEEF);
        checkOutput("t4ToLit",  {31'b0, timeoutOut}, 32'd1);
        checkOutput("t4StbLit", {31'b0, sStb}, 32'd0);
        nextCycle();
        applyStimulus(0, 0, 1, 32'h1111_2222);
        checkOutput("t4DrainAck0Lit", {31'b0, m0Ack}, 32'd0);
        checkOutput("t4DrainAck1Lit", {31'b0, m1Ack}, 32'd0);
        nextCycle();
        runCycle(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 32'h3333_4444);
        checkOutput("t4M1AckLit", {31'b0, m1Ack}, 32'd1);
        checkOutput("t4M1ToLit",  {31'b0, timeoutOut}, 32'd0);
        nextCycle();
        runCycle(0, 0, 0, 0);

        // Ack lands exactly on the watchdog terminal cycle: normal completion
        runCycle(1, 0, 0, 0);
        for (int i = 0; i < LIMIT; i++) runCycle(1, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h55AA_55AA);
        checkOutput("t5AckLit", {31'b0, m0Ack}, 32'd1);
        checkOutput("t5RdtLit", m0Rdt, 32'h55AA_55AA);
        checkOutput("t5ToLit",  {31'b0, timeoutOut}, 32'd0);
        nextCycle();
        runCycle(0, 0, 0, 0);

        // m1 abandons mid-BUSY: no ack, last stays m0 so m1 wins the next tie
        runCycle(0, 1, 0, 0);
        runCycle(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t6AbortAckLit", {31'b0, m1Ack}, 32'd0);
        nextCycle();
        runCycle(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("t6TieGrantLit", {30'b0, grant}, 32'd2);
        nextCycle();
        runCycle(1, 1, 1, 32'h7777_0000);
        runCycle(0, 0, 0, 0);

        // Asynchronous reset in the middle of a BUSY cycle
        runCycle(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t7BusyStbLit", {31'b0, sStb}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t7RstStbLit",   {31'b0, sStb}, 32'd0);
        checkOutput("t7RstGrantLit", {30'b0, grant}, 32'd0);
        nextCycle();
        runCycle(1, 1, 1, 32'h9999_9999);
        rst_n = 1'b1;
        applyStimulus(1, 1, 1, 32'h9999_9999);
        checkOutput("t7StaleAckLit", {31'b0, m1Ack}, 32'd0);
        nextCycle();
        applyStimulus(1, 1, 0, 0);
        checkOutput("t7PostGrantLit", {30'b0, grant}, 32'd1);
        nextCycle();
        runCycle(1, 1, 1, 32'h0BAD_F00D);
        runCycle(0, 0, 0, 0);
        runCycle(0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
